// File: rtl/signal_conflict_monitor.sv
// signal_conflict_monitor: registers four lamp codes, trips into a flashing-yellow fail-safe on persistent conflicts.
// Optional SIGNAL_CONFLICT_LOG_EN adds a saturating count of fail-safe entries.
module signal_conflict_monitor #(
  parameter int TICK_DIV = 25000000,
  parameter int CONFLICT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] north_in,
  input  logic [1:0] east_in,
  input  logic [1:0] south_in,
  input  logic [1:0] west_in,
  input  logic       clear,
  output logic [7:0] lamp_out,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       blink_phase,
  output logic [7:0] conflict_count
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(CONFLICT_CYCLES + 1);
  localparam logic [PW-1:0] LAST_TICK = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LAST_HIT = CW'(CONFLICT_CYCLES - 1);
  typedef enum logic [1:0] {NORMAL, PENDING, FAILSAFE} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic [CW-1:0] hits;
  logic [3:0] green;
  logic [7:0] packed_in;
  logic illegal, multi_green, conflict, wrap, phase_n, trip;
  always_comb begin
    packed_in = {north_in, east_in, south_in, west_in};
    green = {north_in == 2'b10, east_in == 2'b10, south_in == 2'b10, west_in == 2'b10};
    illegal = (&north_in) | (&east_in) | (&south_in) | (&west_in);
    multi_green = |(green & (green - 4'd1));
    conflict = multi_green | illegal;
    wrap = presc == LAST_TICK;
    phase_n = wrap ? ~blink_phase : blink_phase;
    trip = conflict && (state == NORMAL ? CONFLICT_CYCLES == 1 : state == PENDING && hits == LAST_HIT);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= NORMAL;
      presc <= '0;
      hits <= '0;
      blink_phase <= 1'b1;
      lamp_out <= 8'h00;
      fault <= 1'b0;
      fault_code <= 3'd0;
    end else begin
      presc <= (trip || wrap) ? '0 : presc + 1'b1;
      blink_phase <= trip ? 1'b1 : phase_n;
      if (trip) begin
        state <= FAILSAFE;
        hits <= '0;
        fault <= 1'b1;
        fault_code <= {1'b0, illegal, multi_green};
        lamp_out <= 8'h55;
      end else if (state == FAILSAFE) begin
        if (clear && !conflict) begin
          state <= NORMAL;
          fault <= 1'b0;
          fault_code <= 3'd0;
          lamp_out <= packed_in;
        end else
          lamp_out <= {4{1'b0, phase_n}};
      end else begin
        state <= conflict ? PENDING : NORMAL;
        hits <= conflict ? hits + 1'b1 : '0;
        lamp_out <= packed_in;
      end
    end
  end
`ifdef SIGNAL_CONFLICT_LOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      conflict_count <= 8'h00;
    else if (trip && conflict_count != 8'hFF)
      conflict_count <= conflict_count + 8'd1;
  end
`else
  assign conflict_count = 8'h00;
`endif
endmodule
